// File: rtl/code_lock_pkg.sv
// Shared types and sizing helpers for the serial code lock.
// CODE_LOCK_PROG_EN adds a programmable code register.
package code_lock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CHECK,
    UNLOCKED,
    LOCKOUT
  } state_t;

  localparam int UNLOCK_CYC_DEF  = 16;
  localparam int LOCKOUT_CYC_DEF = 1024;
  localparam int TIMEOUT_CYC_DEF = 255;

  function automatic int tmr_width(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

  localparam int TMR_W = tmr_width(
    UNLOCK_CYC_DEF, LOCKOUT_CYC_DEF, TIMEOUT_CYC_DEF);

endpackage

// File: rtl/serial_code_lock_ctrl_if.sv
// Serial input / status bundle of the code lock.
// CODE_LOCK_PROG_EN adds prog_en and prog_bit.
interface serial_code_lock_ctrl_if #(
  parameter int FAIL_W = 2
);
  logic              bit_in;
  logic              bit_valid;
  logic              abort;
`ifdef CODE_LOCK_PROG_EN
  logic              prog_en;
  logic              prog_bit;
`endif
  logic              unlock;
  logic              fail_pulse;
  logic              locked_out;
  logic              busy;
  logic [FAIL_W-1:0] fail_count;

`ifdef CODE_LOCK_PROG_EN
  modport master (
    output bit_in, bit_valid, abort,
    output prog_en, prog_bit,
    input  unlock, fail_pulse, locked_out,
    input  busy, fail_count
  );
  modport slave (
    input  bit_in, bit_valid, abort,
    input  prog_en, prog_bit,
    output unlock, fail_pulse, locked_out,
    output busy, fail_count
  );
`else
  modport master (
    output bit_in, bit_valid, abort,
    input  unlock, fail_pulse, locked_out,
    input  busy, fail_count
  );
  modport slave (
    input  bit_in, bit_valid, abort,
    output unlock, fail_pulse, locked_out,
    output busy, fail_count
  );
`endif

endinterface

// File: rtl/code_lock_shreg.sv
// MSB-first shift register, bit counter and code compare.
// word_full flags the shift that completes a word.
module code_lock_shreg #(
  parameter int CODE_LEN = 40
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                shift_en,
  input  logic                bit_in,
  input  logic [CODE_LEN-1:0] code,
  output logic                word_full,
  output logic                match
);

  localparam int CW = $clog2(CODE_LEN + 1);

  logic [CODE_LEN-1:0] shreg_q, shreg_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (clr) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (shift_en) begin
      shreg_d = {shreg_q[CODE_LEN-2:0], bit_in};
      if (cnt_q != CW'(CODE_LEN))
        cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign word_full = shift_en &&
                     (cnt_q == CW'(CODE_LEN - 1));
  assign match     = (shreg_q == code);

endmodule

// File: rtl/serial_code_lock_ctrl.sv
// Code lock sequencer: FSM, shared cycle timer, fail count.
// CODE_LOCK_PROG_EN enables the programmable code register.
module serial_code_lock_ctrl
  import code_lock_pkg::*;
#(
  parameter int                CODE_LEN    = 40,
  parameter logic [CODE_LEN-1:0] CODE      = 40'hB4_96_A5_C8_11,
  parameter int                MAX_FAIL    = 3,
  parameter int                UNLOCK_CYC  = UNLOCK_CYC_DEF,
  parameter int                LOCKOUT_CYC = LOCKOUT_CYC_DEF,
  parameter int                TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic                    clk,
  input logic                    rst,
  serial_code_lock_ctrl_if.slave io
);

  localparam int TW_P = tmr_width(
    UNLOCK_CYC, LOCKOUT_CYC, TIMEOUT_CYC);
  localparam int TW = (TW_P > TMR_W) ? TW_P : TMR_W;
  localparam int FW = $clog2(MAX_FAIL + 1);

  state_t              state_q, state_d;
  logic [TW-1:0]       tmr_q, tmr_d, tmr_inc;
  logic [FW-1:0]       fail_q, fail_d, fail_nx;
  logic [FW-1:0]       fail_out_q, fail_out_d;
  logic                miss_q, miss_d;
  logic                unlock_q, unlock_d;
  logic                fail_pulse_q, fail_pulse_d;
  logic                locked_out_q, locked_out_d;
  logic                busy_q, busy_d;
  logic                shift_en, clr, acc;
  logic                word_full, match;
  logic [CODE_LEN-1:0] code;

`ifdef CODE_LOCK_PROG_EN
  logic [CODE_LEN-1:0] code_q, code_d;
  logic                prog_ok;

  // programming only counts in IDLE once lockout has cleared
  assign prog_ok = (state_q == IDLE) && !locked_out_q &&
                   io.prog_en;
  assign acc     = io.bit_valid && !prog_ok;
  assign code    = code_q;

  always_comb begin
    code_d = code_q;
    if (prog_ok && io.bit_valid)
      code_d = {code_q[CODE_LEN-2:0], io.prog_bit};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) code_q <= CODE;
    else     code_q <= code_d;
  end
`else
  assign acc  = io.bit_valid;
  assign code = CODE;
`endif

  always_comb begin
    state_d  = state_q;
    fail_d   = fail_q;
    miss_d   = 1'b0;
    shift_en = 1'b0;
    tmr_inc  = (&tmr_q) ? tmr_q : tmr_q + 1'b1;
    tmr_d    = tmr_inc;
    fail_nx  = (fail_q == FW'(MAX_FAIL)) ?
               fail_q : fail_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (acc) begin
          shift_en = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (io.abort) begin
          state_d = IDLE;
        end else if (io.bit_valid) begin
          shift_en = 1'b1;
          tmr_d    = '0;
          if (word_full) state_d = CHECK;
        end else if (tmr_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d = IDLE;
        end
      end
      CHECK: begin
        if (match) begin
          fail_d  = '0;
          state_d = UNLOCKED;
        end else begin
          miss_d  = 1'b1;
          fail_d  = fail_nx;
          state_d = (fail_nx == FW'(MAX_FAIL)) ?
                    LOCKOUT : IDLE;
        end
      end
      UNLOCKED: begin
        if (tmr_q == TW'(UNLOCK_CYC - 1))
          state_d = IDLE;
      end
      LOCKOUT: begin
        if (tmr_q == TW'(LOCKOUT_CYC - 1)) begin
          fail_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) tmr_d = '0;
  end

  assign clr = (state_d == IDLE);

  // outputs trail the state by one register stage
  always_comb begin
    unlock_d     = (state_q == UNLOCKED);
    locked_out_d = (state_q == LOCKOUT);
    busy_d       = (state_q != IDLE);
    fail_pulse_d = miss_q;
    fail_out_d   = fail_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tmr_q        <= '0;
      fail_q       <= '0;
      miss_q       <= 1'b0;
      unlock_q     <= 1'b0;
      fail_pulse_q <= 1'b0;
      locked_out_q <= 1'b0;
      busy_q       <= 1'b0;
      fail_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      fail_q       <= fail_d;
      miss_q       <= miss_d;
      unlock_q     <= unlock_d;
      fail_pulse_q <= fail_pulse_d;
      locked_out_q <= locked_out_d;
      busy_q       <= busy_d;
      fail_out_q   <= fail_out_d;
    end
  end

  code_lock_shreg #(
    .CODE_LEN (CODE_LEN)
  ) u_shreg (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .shift_en  (shift_en),
    .bit_in    (io.bit_in),
    .code      (code),
    .word_full (word_full),
    .match     (match)
  );

  assign io.unlock     = unlock_q;
  assign io.fail_pulse = fail_pulse_q;
  assign io.locked_out = locked_out_q;
  assign io.busy       = busy_q;
  assign io.fail_count = fail_out_q;

endmodule

// File: tb/tb_serial_code_lock_ctrl.sv
// Directed bench for serial_code_lock_ctrl.
// CODE_LOCK_PROG_EN adds the code programming steps.
module tb_serial_code_lock_ctrl;

  localparam logic [39:0] CODE = 40'hB4_96_A5_C8_11;
  localparam logic [39:0] BAD1 = CODE ^ 40'h00_0000_0001;
  localparam logic [39:0] BAD2 = CODE ^ 40'h80_0000_0000;
  localparam logic [39:0] BAD3 = CODE ^ 40'h00_0010_0000;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_code_lock_ctrl_if #(.FAIL_W(2)) io ();

  serial_code_lock_ctrl dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(
    input string       tag,
    input logic [39:0] got,
    input logic [39:0] exp
  );
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bits(
    input logic [39:0] w,
    input int          n
  );
    for (int i = 39; i > 39 - n; i--) begin
      io.bit_in    = w[i];
      io.bit_valid = 1'b1;
      tick(1);
    end
    io.bit_valid = 1'b0;
  endtask

  task automatic send_word(input logic [39:0] w);
    send_bits(w, 40);
  endtask

  initial begin
    rst          = 1'b1;
    io.bit_in    = 1'b0;
    io.bit_valid = 1'b0;
    io.abort     = 1'b0;
`ifdef CODE_LOCK_PROG_EN
    io.prog_en   = 1'b0;
    io.prog_bit  = 1'b0;
`endif
    tick(2);
    check("rst_unlock", io.unlock, 0);
    check("rst_fail_pulse", io.fail_pulse, 0);
    check("rst_locked_out", io.locked_out, 0);
    check("rst_busy", io.busy, 0);
    check("rst_fail_count", io.fail_count, 0);
    rst = 1'b0;

    // correct word: unlock from edge 42 for 16 cycles
    send_word(CODE);
    check("busy_shift", io.busy, 1);
    check("unlock_n", io.unlock, 0);
    tick(1);
    check("unlock_n1", io.unlock, 0);
    tick(1);
    check("unlock_n2", io.unlock, 1);
    check("match_fail_count", io.fail_count, 0);
    tick(15);
    check("unlock_last", io.unlock, 1);
    tick(1);
    check("unlock_end", io.unlock, 0);
    check("busy_idle", io.busy, 0);

    // single mismatch
    send_word(BAD1);
    tick(1);
    check("fail_pulse_n1", io.fail_pulse, 0);
    tick(1);
    check("fail_pulse_n2", io.fail_pulse, 1);
    check("fail_count_1", io.fail_count, 1);
    check("bad_no_unlock", io.unlock, 0);
    tick(1);
    check("fail_pulse_one", io.fail_pulse, 0);

    // two more mismatches -> lockout
    send_word(BAD2);
    tick(2);
    check("fail_pulse_2", io.fail_pulse, 1);
    check("fail_count_2", io.fail_count, 2);
    check("not_locked_2", io.locked_out, 0);
    send_word(BAD3);
    tick(2);
    check("locked_out_on", io.locked_out, 1);
    check("fail_count_3", io.fail_count, 3);
    send_word(CODE);
    tick(2);
    check("lockout_ignore", io.unlock, 0);
    check("locked_mid", io.locked_out, 1);
    tick(981);
    check("locked_last", io.locked_out, 1);
    tick(1);
    check("locked_end", io.locked_out, 0);
    check("lockout_clr_cnt", io.fail_count, 0);

    // partial word then timeout
    send_word(BAD1);
    tick(2);
    check("to_pre_count", io.fail_count, 1);
    send_bits(CODE, 20);
    tick(255);
    check("to_busy_last", io.busy, 1);
    tick(1);
    check("to_idle", io.busy, 0);
    check("to_fail_count", io.fail_count, 1);
    check("to_no_pulse", io.fail_pulse, 0);
    send_word(CODE);
    tick(2);
    check("to_then_unlock", io.unlock, 1);
    check("to_unlock_cnt", io.fail_count, 0);
    tick(16);
    check("to_unlock_end", io.unlock, 0);

    // abort wins over bit_valid at bit 30
    send_word(BAD2);
    tick(2);
    check("ab_pre_count", io.fail_count, 1);
    send_bits(CODE, 29);
    io.bit_in    = CODE[10];
    io.bit_valid = 1'b1;
    io.abort     = 1'b1;
    tick(1);
    io.bit_valid = 1'b0;
    io.abort     = 1'b0;
    tick(1);
    check("ab_idle", io.busy, 0);
    tick(2);
    check("ab_no_pulse", io.fail_pulse, 0);
    check("ab_fail_count", io.fail_count, 1);
    send_word(CODE);
    tick(2);
    check("ab_then_unlock", io.unlock, 1);

    // async reset mid-UNLOCKED
    tick(5);
    check("pre_rst_unlock", io.unlock, 1);
    rst = 1'b1;
    #2;
    check("async_rst_unlock", io.unlock, 0);
    check("async_rst_busy", io.busy, 0);
    rst = 1'b0;
    tick(3);
    check("post_rst_unlock", io.unlock, 0);

`ifdef CODE_LOCK_PROG_EN
    io.prog_en   = 1'b1;
    io.prog_bit  = 1'b0;
    io.bit_valid = 1'b1;
    tick(40);
    io.bit_valid = 1'b0;
    io.prog_en   = 1'b0;
    tick(1);
    check("prog_busy", io.busy, 0);
    send_word(40'h0);
    tick(2);
    check("prog_unlock", io.unlock, 1);
    tick(16);
    send_word(CODE);
    tick(2);
    check("prog_old_fail", io.fail_pulse, 1);
    check("prog_old_unlock", io.unlock, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
